// File: rtl/spi_ram_port_if.sv
// Command/response bus between the SPI slave and the RAM port:
// rx frames from the slave in, read data and its valid strobe back out.
interface spi_ram_port_if #(
  parameter int ADDR_SIZE = 8
);
  logic [ADDR_SIZE+1:0] din;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] dout;
  logic                 tx_valid;

  modport master (output din, rx_valid, input dout, tx_valid);
  modport slave  (input din, rx_valid, output dout, tx_valid);
endinterface

// File: rtl/spi_ram_port.sv
// Command-decoding single-port RAM behind an SPI slave: address load, write, read.
// Optional macro RAM_AUTO_INC_EN: post-increment wr_addr/rd_addr after write/accepted read.
module spi_ram_port #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter int TX_HOLD   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_port_if.slave  bus
);

  localparam int CNT_W = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic {IDLE, TX_BUSY} state_t;

  state_t               state, state_nxt;
  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr, wr_addr_nxt;
  logic [ADDR_SIZE-1:0] rd_addr, rd_addr_nxt;
  logic [ADDR_SIZE-1:0] dout_q;
  logic [ADDR_SIZE-1:0] payload;
  logic [1:0]           opcode;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 tx_q, tx_nxt;
  logic                 wr_en, rd_accept;

  assign opcode  = bus.din[ADDR_SIZE+1:ADDR_SIZE];
  assign payload = bus.din[ADDR_SIZE-1:0];

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_q;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tx_nxt      = tx_q;
    wr_addr_nxt = wr_addr;
    rd_addr_nxt = rd_addr;
    wr_en       = 1'b0;
    rd_accept   = 1'b0;

    // Read-data is only honoured when no byte is being shifted out.
    case (state)
      IDLE: begin
        if (bus.rx_valid && opcode == OP_RD_DATA) begin
          rd_accept = 1'b1;
          tx_nxt    = 1'b1;
          cnt_nxt   = CNT_W'(TX_HOLD - 1);
          state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (cnt == '0) begin
          tx_nxt    = 1'b0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (bus.rx_valid) begin
      case (opcode)
        OP_WR_ADDR: wr_addr_nxt = payload;
        OP_WR_DATA: wr_en       = 1'b1;
        OP_RD_ADDR: rd_addr_nxt = payload;
        default:    ;
      endcase
    end

`ifdef RAM_AUTO_INC_EN
    // Opcodes are exclusive, so an explicit load never coincides with an increment.
    if (wr_en)     wr_addr_nxt = wr_addr + ADDR_SIZE'(1);
    if (rd_accept) rd_addr_nxt = rd_addr + ADDR_SIZE'(1);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      tx_q    <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      dout_q  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      tx_q    <= tx_nxt;
      wr_addr <= wr_addr_nxt;
      rd_addr <= rd_addr_nxt;
      if (rd_accept) dout_q <= mem[rd_addr];
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= payload;
  end

endmodule

// File: tb/tb_spi_ram_port.sv
// Randomised and directed bench for spi_ram_port against a behavioural command model.
// Honours RAM_AUTO_INC_EN the same way the design does.
module tb_spi_ram_port;

  localparam int AS    = 8;
  localparam int DEPTH = 256;
  localparam int HOLD  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   run   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  spi_ram_port_if #(.ADDR_SIZE(AS)) bus ();

  spi_ram_port #(.ADDR_SIZE(AS), .MEM_DEPTH(DEPTH), .TX_HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: memory contents, current addresses, remaining tx window.
  logic [AS-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH] = '{default: 1'b0};
  logic [AS-1:0] m_wr, m_rd, m_dout;
  bit            m_dout_known;
  int            m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr         <= '0;
      m_rd         <= '0;
      m_dout       <= '0;
      m_dout_known <= 1'b1;
      m_left       <= 0;
    end else begin
      if (m_left > 0) m_left <= m_left - 1;
      if (bus.rx_valid) begin
        case (bus.din[AS+1:AS])
          2'b00: m_wr <= bus.din[AS-1:0];
          2'b01: begin
            m_mem[m_wr]   <= bus.din[AS-1:0];
            m_known[m_wr] <= 1'b1;
`ifdef RAM_AUTO_INC_EN
            m_wr <= m_wr + 8'd1;
`endif
          end
          2'b10: m_rd <= bus.din[AS-1:0];
          default: begin
            if (m_left == 0) begin
              m_dout       <= m_mem[m_rd];
              m_dout_known <= m_known[m_rd];
              m_left       <= HOLD;
`ifdef RAM_AUTO_INC_EN
              m_rd <= m_rd + 8'd1;
`endif
            end
          end
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("model_tx_valid", 32'(bus.tx_valid), 32'(m_left > 0));
      if (m_dout_known) chk("model_dout", 32'(bus.dout), 32'(m_dout));
    end
  end

  task automatic drive(input logic [AS+1:0] f, input logic v);
    @(negedge clk);
    bus.din      = v ? f : (AS+2)'($urandom);
    bus.rx_valid = v;
  endtask

  task automatic send(input logic [AS+1:0] f);
    drive(f, 1'b1);
    drive('0, 1'b0);
  endtask

  task automatic window_len(input string name, input int first);
    int n;
    n = first;
    while (bus.tx_valid === 1'b1 && n <= 20) begin
      n++;
      drive('0, 1'b0);
    end
    chk(name, 32'(n), 32'(HOLD));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t: got no finish, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [AS-1:0] exp1, exp2;
    bus.din      = '0;
    bus.rx_valid = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;

    // Idle after reset
    repeat (5) drive('0, 1'b0);
    chk("reset_dout", 32'(bus.dout), 32'h00);
    chk("reset_tx_valid", 32'(bus.tx_valid), 32'h0);

    // Basic write then read
    send(10'h005);
    send(10'h1A5);
    send(10'h205);
    chk("pre_read_tx_valid", 32'(bus.tx_valid), 32'h0);
    send(10'h300);
    chk("read_tx_rise", 32'(bus.tx_valid), 32'h1);
    chk("read_dout", 32'(bus.dout), 32'hA5);
    window_len("read_window_len", 0);
    chk("read_tx_fall", 32'(bus.tx_valid), 32'h0);

    // Read-data inside the window is ignored; an address load still executes
    send(10'h006);
    send(10'h15A);
    drive(10'h205, 1'b1);
    send(10'h300);
    chk("busy_first_dout", 32'(bus.dout), 32'hA5);
    n = 0;
    while (bus.tx_valid === 1'b1 && n <= 20) begin
      n++;
      chk("busy_dout_held", 32'(bus.dout), 32'hA5);
      if (n == 3)      drive(10'h206, 1'b1);
      else if (n == 4) drive(10'h3FF, 1'b1);
      else             drive('0, 1'b0);
    end
    chk("busy_window_len", 32'(n), 32'(HOLD));
    send(10'h300);
    chk("busy_rd_load_dout", 32'(bus.dout), 32'h5A);
    window_len("busy_followup_len", 0);

    // Top address, back-to-back rd_addr load and read
    send(10'h0FF);
    send(10'h1FF);
    drive(10'h2FF, 1'b1);
    send(10'h300);
    chk("top_addr_dout", 32'(bus.dout), 32'hFF);
    window_len("top_addr_len", 0);

    // Asynchronous reset in the middle of a window
    send(10'h000);
    send(10'h177);
    drive(10'h205, 1'b1);
    send(10'h300);
    repeat (3) drive('0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("async_rst_dout", 32'(bus.dout), 32'h00);
    repeat (2) drive('0, 1'b0);
    rst_n = 1'b1;
    send(10'h300);
    chk("post_rst_tx_valid", 32'(bus.tx_valid), 32'h1);
    chk("post_rst_dout", 32'(bus.dout), 32'h77);
    window_len("post_rst_len", 0);

    // Auto-increment sequence
`ifdef RAM_AUTO_INC_EN
    exp1 = 8'h11;
    exp2 = 8'h22;
`else
    exp1 = 8'h22;
    exp2 = 8'h22;
`endif
    send(10'h010);
    send(10'h111);
    send(10'h122);
    send(10'h210);
    send(10'h300);
    chk("autoinc_first", 32'(bus.dout), 32'(exp1));
    window_len("autoinc_first_len", 0);
    send(10'h300);
    chk("autoinc_second", 32'(bus.dout), 32'(exp2));
    window_len("autoinc_second_len", 0);

    // Fill the whole memory, then random traffic against the model
    for (int a = 0; a < DEPTH; a++) begin
      drive({2'b00, 8'(a)}, 1'b1);
      drive({2'b01, 8'($urandom)}, 1'b1);
    end
    drive('0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      drive((AS+2)'($urandom), ($urandom_range(0, 2) != 0));
    end
    repeat (12) drive('0, 1'b0);

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
